// File: rtl/dbg_bus_pkg.sv
// Shared constants and types for the debug bus master: opcodes,
// response bytes and the command FSM state encoding.
package dbg_bus_pkg;

   localparam logic [7:0] OP_WRITE   = 8'h57;  // 'W'
   localparam logic [7:0] OP_BEWRITE = 8'h42;  // 'B'
   localparam logic [7:0] OP_READ    = 8'h52;  // 'R'

   localparam logic [7:0] RSP_OK     = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_ERR    = 8'h3F;  // '?'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BE,
      ST_ADDR,
      ST_DATA,
      ST_STROBE,
      ST_WAIT,
      ST_SEND
   } state_t;

   // True for the three opcodes the master understands.
   function automatic logic op_known(input logic [7:0] op);
      return (op == OP_WRITE) || (op == OP_BEWRITE) || (op == OP_READ);
   endfunction

endpackage

// File: rtl/dbg_bus_master_if.sv
// Host byte streams plus peripheral bus seen by the debug bus master.
// The master modport is the bus-master side; slave is the host/responder side.
interface dbg_bus_master_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_we;
   logic        bus_en;
   logic [31:0] bus_rdata;
   logic        busy;

   modport master (
      input  rx_data, rx_valid, tx_ready, bus_rdata,
      output rx_ready, tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_en, busy
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, bus_rdata,
      input  rx_ready, tx_data, tx_valid, bus_addr, bus_wdata, bus_we, bus_en, busy
   );

endinterface

// File: rtl/dbg_bus_tx_serializer.sv
// Response serializer: loads a word and a byte count (1 or 4) and emits the
// bytes MSB-first over a valid/ready handshake. The current byte is always
// shift_reg[31:24], so tx_data is stable while the sink stalls.
module dbg_bus_tx_serializer (
   input  logic        clk_100M,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic [2:0]  load_cnt,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        done
);

   logic [31:0] shift_reg;
   logic [2:0]  left_reg;
   logic        valid_reg;

   assign tx_data  = shift_reg[31:24];
   assign tx_valid = valid_reg;
   // Pulses on the handshake cycle that consumes the final byte.
   assign done     = valid_reg & tx_ready & (left_reg == 3'd1);

   // Load a new response, then advance one byte per accepted handshake.
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         shift_reg <= '0;
         left_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         shift_reg <= load_word;
         left_reg  <= load_cnt;
         valid_reg <= 1'b1;
      end else if (valid_reg && tx_ready) begin
         left_reg <= left_reg - 3'd1;
         if (left_reg == 3'd1) begin
            valid_reg <= 1'b0;
         end else begin
            shift_reg <= {shift_reg[23:0], 8'h00};
         end
      end
   end

endmodule

// File: rtl/dbg_bus_master.sv
// Debug bus master: parses host commands from the UART receive byte stream,
// issues one 32-bit bus read or write, and returns the response bytes on the
// UART transmit stream. One command is in flight at a time.
module dbg_bus_master
   import dbg_bus_pkg::*;
#(
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 1000000,
   parameter int TO_W    = 20
) (
   input  logic              clk_100M,
   input  logic              rst,
   dbg_bus_master_if.master  bif
);

   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [7:0]      WAIT_LAST = 8'(RD_LAT - 1);

   state_t          state_reg;
   logic [1:0]      byte_cnt_reg;
   logic [31:0]     field_reg;
   logic [31:0]     addr_reg;     // write address, parked until the data field completes
   logic [3:0]      be_reg;
   logic            is_read_reg;
   logic [TO_W-1:0] to_cnt_reg;
   logic [7:0]      wait_cnt_reg;
   logic [31:0]     bus_addr_reg;
   logic [31:0]     bus_wdata_reg;
   logic [3:0]      bus_we_reg;
   logic            bus_en_reg;

   logic            rx_ready;
   logic            rx_fire;
   logic            collecting;
   logic            last_byte;
   logic [31:0]     field_next;
   logic            ser_load;
   logic [31:0]     ser_word;
   logic [2:0]      ser_cnt;
   logic            ser_done;

   assign collecting = (state_reg == ST_BE) || (state_reg == ST_ADDR) || (state_reg == ST_DATA);
   assign rx_ready   = (state_reg == ST_IDLE) || collecting;
   assign rx_fire    = bif.rx_valid & rx_ready;
   assign last_byte  = (byte_cnt_reg == 2'd3);
   assign field_next = {field_reg[23:0], bif.rx_data};

   assign bif.rx_ready  = rx_ready;
   assign bif.bus_addr  = bus_addr_reg;
   assign bif.bus_wdata = bus_wdata_reg;
   assign bif.bus_we    = bus_we_reg;
   assign bif.bus_en    = bus_en_reg;
   assign bif.busy      = (state_reg != ST_IDLE);

   // Pick the response to hand the serializer on the cycle the FSM enters SEND.
   always_comb begin
      ser_load = 1'b0;
      ser_word = '0;
      ser_cnt  = 3'd1;
      case (state_reg)
         ST_IDLE: begin
            if (rx_fire && !op_known(bif.rx_data)) begin
               ser_load = 1'b1;
               ser_word = {RSP_ERR, 24'h0};
            end
         end
         ST_STROBE: begin
            if (!is_read_reg) begin
               ser_load = 1'b1;
               ser_word = {RSP_OK, 24'h0};
            end
         end
         ST_WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               ser_load = 1'b1;
               ser_word = bif.bus_rdata;
               ser_cnt  = 3'd4;
            end
         end
         default: ;
      endcase
   end

   // Command FSM: opcode decode, field collection, bus strobe, read wait, send.
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         byte_cnt_reg  <= '0;
         field_reg     <= '0;
         addr_reg      <= '0;
         be_reg        <= '0;
         is_read_reg   <= 1'b0;
         to_cnt_reg    <= '0;
         wait_cnt_reg  <= '0;
         bus_addr_reg  <= '0;
         bus_wdata_reg <= '0;
         bus_we_reg    <= '0;
         bus_en_reg    <= 1'b0;
      end else begin
         // The strobe is one cycle wide; it is re-armed only on a transition into STROBE.
         bus_en_reg <= 1'b0;
         bus_we_reg <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (rx_fire) begin
                  byte_cnt_reg <= '0;
                  case (bif.rx_data)
                     OP_WRITE: begin
                        is_read_reg <= 1'b0;
                        be_reg      <= 4'hF;
                        state_reg   <= ST_ADDR;
                     end
                     OP_BEWRITE: begin
                        is_read_reg <= 1'b0;
                        state_reg   <= ST_BE;
                     end
                     OP_READ: begin
                        is_read_reg <= 1'b1;
                        be_reg      <= 4'h0;
                        state_reg   <= ST_ADDR;
                     end
                     default: state_reg <= ST_SEND;
                  endcase
               end
            end
            ST_BE: begin
               if (rx_fire) begin
                  be_reg    <= bif.rx_data[3:0];
                  state_reg <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (rx_fire) begin
                  field_reg    <= field_next;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (last_byte && is_read_reg) begin
                     bus_addr_reg <= field_next;
                     bus_en_reg   <= 1'b1;
                     state_reg    <= ST_STROBE;
                  end else if (last_byte) begin
                     addr_reg  <= field_next;
                     state_reg <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (rx_fire) begin
                  field_reg    <= field_next;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (last_byte) begin
                     bus_addr_reg  <= addr_reg;
                     bus_wdata_reg <= field_next;
                     bus_we_reg    <= be_reg;
                     bus_en_reg    <= 1'b1;
                     state_reg     <= ST_STROBE;
                  end
               end
            end
            ST_STROBE: begin
               wait_cnt_reg <= '0;
               state_reg    <= is_read_reg ? ST_WAIT : ST_SEND;
            end
            ST_WAIT: begin
               if (wait_cnt_reg == WAIT_LAST) begin
                  state_reg <= ST_SEND;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            ST_SEND: begin
               if (ser_done) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase

         // Inter-byte timeout: a stalled host abandons the half-received command.
         if (collecting) begin
            if (rx_fire) begin
               to_cnt_reg <= '0;
            end else if (to_cnt_reg == TO_LAST) begin
               to_cnt_reg   <= '0;
               byte_cnt_reg <= '0;
               state_reg    <= ST_IDLE;
            end else begin
               to_cnt_reg <= to_cnt_reg + 1'b1;
            end
         end else begin
            to_cnt_reg <= '0;
         end
      end
   end

   dbg_bus_tx_serializer u_tx_ser (
      .clk_100M  (clk_100M),
      .rst       (rst),
      .load      (ser_load),
      .load_word (ser_word),
      .load_cnt  (ser_cnt),
      .tx_ready  (bif.tx_ready),
      .tx_data   (bif.tx_data),
      .tx_valid  (bif.tx_valid),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed bench for dbg_bus_master: W, R, B, unknown opcode, timeout and
// reset during a stalled SEND, against a registered-read responder model.
module tb_dbg_bus_master;

   logic clk_100M = 1'b0;
   logic rst;

   dbg_bus_master_if bif ();

   dbg_bus_master #(
      .RD_LAT  (1),
      .TIMEOUT (100),
      .TO_W    (20)
   ) dut (
      .clk_100M (clk_100M),
      .rst      (rst),
      .bif      (bif.master)
   );

   always #5 clk_100M = ~clk_100M;

   int n_checks = 0;
   int n_pass   = 0;
   int en_cnt   = 0;
   int wide_cnt = 0;
   logic en_prev = 1'b0;
   logic [7:0] tx_q[$];

   // Responder read data for a given address.
   function automatic logic [31:0] rd_model(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_1234;
         32'h0000_0004: return 32'hCAFE_F00D;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   // Responder: registers read data once on a read strobe.
   always @(posedge clk_100M) begin
      if (rst)
         bif.bus_rdata <= '0;
      else if (bif.bus_en && bif.bus_we == 4'h0)
         bif.bus_rdata <= rd_model(bif.bus_addr);
   end

   // Strobe monitor: counts accesses and strobes longer than one cycle.
   always @(posedge clk_100M) begin
      en_prev <= bif.bus_en;
      if (bif.bus_en) en_cnt <= en_cnt + 1;
      if (bif.bus_en && en_prev) wide_cnt <= wide_cnt + 1;
   end

   // Transmit sink: collects every accepted response byte.
   always @(posedge clk_100M) begin
      if (!rst && bif.tx_valid && bif.tx_ready) tx_q.push_back(bif.tx_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
   endtask

   // Present one byte (called at a negedge) and hold it until accepted.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      while (!bif.rx_ready && n < 200) begin
         @(negedge clk_100M);
         n++;
      end
      if (!bif.rx_ready) check("rx_accept_bound", 32'(n), 32'd0);
      @(negedge clk_100M);
      bif.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic wait_tx(input string tag, input int n);
      int t = 0;
      while (tx_q.size() < n && t < 200) begin
         @(negedge clk_100M);
         t++;
      end
      check(tag, 32'(tx_q.size()), 32'(n));
   endtask

   function automatic logic [31:0] tx_word(input int base);
      if (tx_q.size() < base + 4) return 32'hxxxx_xxxx;
      return {tx_q[base], tx_q[base+1], tx_q[base+2], tx_q[base+3]};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int en0;
      logic [7:0] hold;
      int stable_err;
      int t;

      rst = 1'b1;
      bif.rx_valid = 1'b0;
      bif.rx_data  = 8'h00;
      bif.tx_ready = 1'b1;
      repeat (3) @(negedge clk_100M);
      check("rst_bus_ctl", {27'd0, bif.bus_en, bif.bus_we}, 32'd0);
      check("rst_tx", {22'd0, bif.tx_valid, bif.busy, bif.tx_data}, 32'd0);
      check("rst_rx_ready", 32'(bif.rx_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk_100M);

      // 'W' 0x0000000C <= 0x0000A55A
      send_byte(8'h57); send_word(32'h0000_000C); send_word(32'h0000_A55A);
      check("w_strobe_en", 32'(bif.bus_en), 32'd1);
      check("w_addr", bif.bus_addr, 32'h0000_000C);
      check("w_wdata", bif.bus_wdata, 32'h0000_A55A);
      check("w_we", 32'(bif.bus_we), 32'hF);
      @(negedge clk_100M);
      check("w_en_drop", {27'd0, bif.bus_en, bif.bus_we}, 32'd0);
      check("w_tx_valid", 32'(bif.tx_valid), 32'd1);
      check("w_addr_hold", bif.bus_addr, 32'h0000_000C);
      wait_tx("w_tx_count", 1);
      check("w_rsp", 32'(tx_q[0]), 32'h4B);
      tx_q.delete();
      @(negedge clk_100M);
      check("w_idle", 32'(bif.busy), 32'd0);
      $display("txn W addr=0000000C data=0000A55A");

      // 'R' 0x00000000 -> 00 00 12 34
      send_byte(8'h52); send_word(32'h0000_0000);
      check("r_strobe_en", 32'(bif.bus_en), 32'd1);
      check("r_we", 32'(bif.bus_we), 32'd0);
      @(negedge clk_100M);
      check("r_wait_tx", 32'(bif.tx_valid), 32'd0);
      @(negedge clk_100M);
      check("r_tx_valid", 32'(bif.tx_valid), 32'd1);
      check("r_tx_first", 32'(bif.tx_data), 32'h00);
      wait_tx("r_tx_count", 4);
      check("r_word", tx_word(0), 32'h0000_1234);
      tx_q.delete();
      $display("txn R addr=00000000");

      // 'B' be=3 0x00000008 <= 0xDEADBEEF
      send_byte(8'h42); send_byte(8'h03); send_word(32'h0000_0008); send_word(32'hDEAD_BEEF);
      check("b_strobe_en", 32'(bif.bus_en), 32'd1);
      check("b_we", 32'(bif.bus_we), 32'h3);
      check("b_addr", bif.bus_addr, 32'h0000_0008);
      check("b_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
      wait_tx("b_tx_count", 1);
      check("b_rsp", 32'(tx_q[0]), 32'h4B);
      tx_q.delete();
      $display("txn B be=3 addr=00000008 data=DEADBEEF");

      // Unknown opcode followed immediately by 'R' 0x00000004
      en0 = en_cnt;
      send_byte(8'h00);
      send_byte(8'h52); send_word(32'h0000_0004);
      wait_tx("unk_tx_count", 5);
      check("unk_rsp", 32'(tx_q[0]), 32'h3F);
      check("unk_then_r", tx_word(1), 32'hCAFE_F00D);
      check("unk_en_count", 32'(en_cnt - en0), 32'd1);
      tx_q.delete();
      $display("txn ? then R addr=00000004");

      // Timeout after 'W' plus two address bytes
      en0 = en_cnt;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
      repeat (99) @(negedge clk_100M);
      check("to_busy_before", 32'(bif.busy), 32'd1);
      @(negedge clk_100M);
      check("to_busy_after", 32'(bif.busy), 32'd0);
      check("to_no_strobe", 32'(en_cnt - en0), 32'd0);
      check("to_no_tx", 32'(tx_q.size()), 32'd0);
      send_byte(8'h52); send_word(32'h0000_0000);
      wait_tx("to_r_tx_count", 4);
      check("to_r_word", tx_word(0), 32'h0000_1234);
      tx_q.delete();
      $display("txn timeout then R addr=00000000");

      // Read with the sink stalled, then reset during SEND
      bif.tx_ready = 1'b0;
      send_byte(8'h52); send_word(32'h0000_0008);
      t = 0;
      while (!bif.tx_valid && t < 20) begin
         @(negedge clk_100M);
         t++;
      end
      check("st_tx_valid", 32'(bif.tx_valid), 32'd1);
      check("st_tx_first", 32'(bif.tx_data), 32'h5A);
      hold = bif.tx_data;
      stable_err = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_100M);
         if (bif.tx_data !== hold || bif.tx_valid !== 1'b1) stable_err++;
      end
      check("st_stable", 32'(stable_err), 32'd0);
      check("st_rx_ready", 32'(bif.rx_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk_100M);
      check("st_rst_bus", {27'd0, bif.bus_en, bif.bus_we}, 32'd0);
      check("st_rst_addr", bif.bus_addr | bif.bus_wdata, 32'd0);
      check("st_rst_tx", {22'd0, bif.tx_valid, bif.busy, bif.tx_data}, 32'd0);
      check("st_rst_rx_ready", 32'(bif.rx_ready), 32'd1);
      rst = 1'b0;
      bif.tx_ready = 1'b1;
      repeat (5) @(negedge clk_100M);
      check("st_no_tx", 32'(tx_q.size()), 32'd0);
      $display("txn R addr=00000008 stalled, reset in SEND");

      check("strobe_width", 32'(wide_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dbg_bus_master.md
Name: dbg_bus_master

Overview:
- Byte-stream-to-CPU-bus initiator (master) for the peripheral register file.
- Host commands arrive from a UART receive byte stream; the block issues single 32-bit reads and writes on the peripheral bus, then returns the response bytes on a UART transmit byte stream.
- Lets a host PC peek and poke switch, LED, seg, PS/2, UART and VGA registers without the CPU.
- Sits between the UART byte FIFOs and the bus mux that feeds the peripheral responder.

Parameters:
RD_LAT, 1, cycles from the read strobe to valid bus_rdata (the responder registers its read data once).
TIMEOUT, 1000000, idle cycles allowed between bytes of one command before the command is abandoned.
TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk_100M  in  1  clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received host byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted on a cycle where rx_valid & rx_ready
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  byte consumed on a cycle where tx_valid & tx_ready
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_we  out  4  byte write enables
bus_en  out  1  bus access strobe, one cycle wide
bus_rdata  in  32  bus read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk_100M. On reset all outputs go to 0, state goes to IDLE, and the counters clear. Reset mid-command abandons the command; no bus access and no response are produced.
- Commands: all multi-byte fields are big-endian (MSB first).
  - 0x57 'W': 4 address bytes, then 4 data bytes -> bus write with we=4'hF -> response 0x4B 'K'.
  - 0x42 'B': 1 byte-enable byte (low 4 bits used), 4 address bytes, 4 data bytes -> bus write with we=be[3:0] -> response 'K'.
  - 0x52 'R': 4 address bytes -> bus read -> response of 4 data bytes, MSB first.
  - Any other opcode -> response 0x3F '?', then return to IDLE.
- States:
  - IDLE: accept the opcode.
  - BE: accept the byte-enable byte.
  - ADDR: accept 4 address bytes.
  - DATA: accept 4 data bytes.
  - STROBE: drive one bus cycle.
  - WAIT: count out RD_LAT cycles.
  - SEND: drive the response bytes.
- Byte collection:
  - rx_ready = 1 in IDLE, BE, ADDR and DATA; 0 in STROBE, WAIT and SEND.
  - A 2-bit byte counter indexes the field; bytes shift into the field register from the LSB side.
  - Transition out of the state happens on acceptance of the 4th byte.
- STROBE (exactly 1 cycle):
  - bus_en=1; bus_addr and bus_wdata valid.
  - bus_we = enables for W/B; bus_we = 0 for R.
  - Next cycle: bus_en=0 and bus_we=0.
  - bus_addr and bus_wdata hold their last values afterwards.
- WAIT (reads only):
  - bus_rdata is sampled exactly RD_LAT cycles after the STROBE cycle into a 32-bit response register.
  - Then go to SEND.
- SEND:
  - tx_valid=1 with the current response byte; the byte advances on tx_valid & tx_ready.
  - Response lengths: 1 byte for 'K'/'?', 4 bytes for R.
  - Return to IDLE on acceptance of the last byte.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- Timeout:
  - The counter clears on every accepted byte and counts while in BE, ADDR or DATA.
  - When it reaches TIMEOUT: return to IDLE with no bus access and no response.
  - The timeout does not apply in IDLE or SEND.
- Latency: last command byte accepted -> STROBE on the next cycle. For W, tx_valid is asserted the cycle after STROBE. For R, tx_valid is asserted RD_LAT+1 cycles after STROBE.
- Throughput: a single outstanding command only; the next opcode is accepted only once back in IDLE.
- Unknown opcode: the '?' response is sent even if further bytes follow. Those bytes are then parsed as new opcodes.

Decomposition:
- Shared package (dbg_bus_pkg):
  - Opcode constants: OP_WRITE=0x57, OP_BEWRITE=0x42, OP_READ=0x52.
  - Response constants: RSP_OK=0x4B, RSP_ERR=0x3F.
  - Enumerated state type.
- One natural sub-module, dbg_bus_tx_serializer: loads a 32-bit word plus a byte count (1 or 4) and emits bytes MSB-first over the valid/ready handshake. The FSM, collector and timeout stay in the top.

Test Plan:
- 'W' 00 00 00 0C 00 00 A5 5A, tx_ready=1 -> one cycle bus_en=1, bus_addr=0x0000000C, bus_wdata=0x0000A55A, bus_we=4'hF; then tx byte 0x4B.
- 'R' 00 00 00 00, model returns 0x00001234 after RD_LAT=1 -> tx bytes 00 00 12 34 in order; bus_we=0 during the strobe.
- 'B' 03 00 00 00 08 DE AD BE EF -> bus_we=4'h3, bus_wdata=0xDEADBEEF, bus_addr=0x00000008; response 'K'.
- Opcode 0x00 -> tx byte 0x3F and no bus_en pulse. Then 'R' 00 00 00 04 -> normal 4-byte response.
- 'W' plus 2 address bytes, then silence with TIMEOUT=100 -> no bus_en, no tx_valid; busy drops after 100 cycles. Next 'R' command succeeds.
- Read with tx_ready held low for 50 cycles, then rst asserted during SEND -> tx_data stable while stalled; after reset all outputs are 0, state is IDLE, rx_ready=1.
